// File: rtl/pc_pkg.sv
// pc_pkg: shared state/branch encodings and default widths for the fetch stage.
package pc_pkg;
    localparam int PC_W = 10;
    localparam int TGT_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    typedef enum logic [1:0] {BR_SEQ = 2'b00, BR_ABS = 2'b01, BR_REL = 2'b10, BR_CALL = 2'b11} br_type_t;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection with target zero/sign extension.
module pc_next_calc #(
    parameter int PC_W = pc_pkg::PC_W,
    parameter int TGT_W = pc_pkg::TGT_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  link,
    input  logic [1:0]       br_type,
    input  logic             ret,
    input  logic             cond,
    input  logic [TGT_W-1:0] lut,
    output logic [PC_W-1:0]  next_pc,
    output logic [PC_W-1:0]  link_val,
    output logic             link_we
);
    import pc_pkg::*;
    br_type_t bt;
    logic [PC_W-1:0] abs_pc, rel_pc;
    always_comb begin
        bt = br_type_t'(br_type);
        link_val = pc + PC_W'(1);
        abs_pc = PC_W'(lut);
        rel_pc = pc + {{(PC_W-TGT_W){lut[TGT_W-1]}}, lut};
        next_pc = ret ? link :
                  (bt == BR_ABS || bt == BR_CALL) ? abs_pc :
                  (bt == BR_REL && cond) ? rel_pc : link_val;
        // a return in the same cycle as a call suppresses the link write
        link_we = !ret && bt == BR_CALL;
    end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, one-level link register and start/halt FSM.
module pc_fetch_ctrl #(
    parameter int PC_W = pc_pkg::PC_W,
    parameter int TGT_W = pc_pkg::TGT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic [1:0]       BrType,
    input  logic             Ret,
    input  logic             Cond,
    input  logic [TGT_W-1:0] LutValue,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done
);
    import pc_pkg::*;
    state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, link_q, link_d, calc_pc, calc_link;
    logic calc_we;
    pc_next_calc #(.PC_W(PC_W), .TGT_W(TGT_W)) u_calc (
        .pc(pc_q),
        .link(link_q),
        .br_type(BrType),
        .ret(Ret),
        .cond(Cond),
        .lut(LutValue),
        .next_pc(calc_pc),
        .link_val(calc_link),
        .link_we(calc_we)
    );
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        link_d = link_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) state_d = RUN;
            end
            RUN: if (!Stall) begin
                if (Halt) state_d = HALTED;
                else begin
                    pc_d = calc_pc;
                    if (calc_we) link_d = calc_link;
                end
            end
            HALTED: if (Start && !Stall) begin
                state_d = RUN;
                pc_d = '0;
                link_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q <= '0;
            link_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            link_q <= link_d;
        end
    end
    assign PC = pc_q;
    assign Running = state_q == RUN;
    assign Done = state_q == HALTED;
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-control stage sitting directly downstream of the branch-target lookup table.
- Holds the PC that addresses instruction memory.
- Consumes the 8-bit LUT value as either an absolute target or a signed relative offset.
- Also provides a one-level call/return link register and the start/halt/done handshake to the testbench/top level.

Parameters:
- PC_W, 10, width of program counter and instruction-memory address.
- TGT_W, 8, width of the LUT target/offset value.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level; begins or restarts program execution from PC 0.
- Stall  input  1  freezes PC, link and state for the current cycle.
- Halt  input  1  decoded halt instruction at current PC.
- BrType  input  2  00 sequential, 01 absolute jump, 10 conditional relative branch, 11 call (absolute + link).
- Ret  input  1  return: PC takes link register.
- Cond  input  1  condition flag for BrType 10.
- LutValue  input  TGT_W  target/offset from the PC lookup table.
- PC  output  PC_W  current instruction address.
- Running  output  1  high in RUN state.
- Done  output  1  high in HALTED state.

Behaviour:
- State machine, states IDLE, RUN, HALTED; state register reset asynchronously.
- Reset (any time, mid-operation included): state IDLE, PC=0, link=0, Running=0, Done=0, effective immediately and not waiting for a clock edge.
- IDLE: PC held at 0. Start=1 -> RUN at next edge, PC stays 0, so the first instruction fetched is address 0.
- RUN, Stall=1: PC, link and state all hold. Halt, Ret, BrType and Start are ignored that cycle.
- RUN, Stall=0, next-PC priority, highest first:
  - Halt=1 -> HALTED; PC holds at the halt address.
  - Ret=1 -> PC=link.
  - BrType 01 -> PC=zero-extended LutValue.
  - BrType 11 -> PC=zero-extended LutValue; link=PC+1 on the same edge.
  - BrType 10 with Cond=1 -> PC=PC+sign-extended LutValue.
  - BrType 10 with Cond=0, or BrType 00 -> PC=PC+1.
- Start is ignored in RUN.
- Arithmetic: all PC sums are modulo 2^PC_W, so wrap-around is silent: PC=1023 plus 1 gives 0; PC=2 with offset 0xFD (-3) gives 1023. No overflow flag.
- Ret and call in the same cycle: Ret wins, and link is not updated.
- HALTED: Done=1, PC holds.
  - Start=0 -> stay HALTED.
  - Start=1 with Stall=0 -> RUN with PC=0 and link=0; Done drops on that edge.
  - Start=1 with Stall=1 -> stays HALTED.
- Timing:
  - All next-PC decisions are registered; latency is one cycle from control inputs to PC.
  - PC is a registered output with no combinational input-to-output path.
  - Running and Done decode from state only.
- The link register is one level deep; a nested call overwrites it.

Decomposition:
- Shared package pc_pkg:
  - enum state_t {IDLE, RUN, HALTED}.
  - enum br_type_t {BR_SEQ=2'b00, BR_ABS=2'b01, BR_REL=2'b10, BR_CALL=2'b11}.
  - Localparam defaults PC_W and TGT_W.
- One sub-module, pc_next_calc: purely combinational next-PC selection and sign/zero extension, for unit testing in isolation.
- FSM, PC register and link register stay in pc_fetch_ctrl.

Test Plan:
- Reset and start: Reset pulse, Start=1 for one cycle, BrType=00 for 4 cycles -> PC 0,0,1,2,3; Running=1, Done=0.
- Branches: at PC=5, BrType=01 with LutValue=72 -> PC=72. At PC=72, BrType=10, Cond=1, LutValue=0xFE -> PC=70. At PC=70, BrType=10, Cond=0 -> PC=71.
- Call/return: at PC=10, BrType=11 with LutValue=112 -> PC=112 and link=11; three sequential steps; Ret=1 -> PC=11. Repeat with Ret=1 and BrType=11 together -> PC=old link, link unchanged.
- Stall and wrap: Stall=1 for 3 cycles with BrType=01 -> PC unchanged. PC=1023, BrType=00 -> PC=0. PC=2, BrType=10, Cond=1, LutValue=0xFD -> PC=1023.
- Halt/restart: at PC=40, Halt=1 -> Done=1 and PC=40 held for 5 cycles with Start=0. Start=1 with Stall=1 -> stays HALTED. Start=1 with Stall=0 -> RUN, PC=0, Done=0.
- Async reset mid-run: assert Reset between clock edges at PC=33 -> PC=0, Done=0, Running=0 before the next edge; the FSM returns to IDLE and ignores BrType until Start.
